// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU RAM port arbiter.
package cpu16_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_MAX = 15;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select: fixed priority when last-winner is tied to LDR,
// round-robin when fed a live last-winner register.
module ram_arb_pick
  import cpu16_pkg::*;
(
  input  logic       i_cpu_req,
  input  logic       i_ldr_req,
  input  logic       i_last,
  output logic [1:0] o_win_c
);

  always_comb begin
    o_win_c = 2'b00;
    if (i_cpu_req && i_ldr_req) begin
      if (i_last == PORT_LDR) begin
        o_win_c[PORT_CPU] = 1'b1;
      end else begin
        o_win_c[PORT_LDR] = 1'b1;
      end
    end else if (i_cpu_req) begin
      o_win_c[PORT_CPU] = 1'b1;
    end else if (i_ldr_req) begin
      o_win_c[PORT_LDR] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port (cpu/loader) single-RAM arbiter with IDLE/ACCESS/DONE sequencing.
// Define RAM_ARB_RR_EN for round-robin arbitration; default is fixed cpu priority.
module ram_port_arbiter
  import cpu16_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  input  logic        i_ldr_req,
  input  logic        i_ldr_we,
  input  logic [15:0] i_ldr_addr,
  input  logic [15:0] i_ldr_wdata,
  input  logic [15:0] i_ram_rdata,
  output logic        o_cpu_gnt,
  output logic        o_ldr_gnt,
  output logic        o_cpu_ack,
  output logic        o_ldr_ack,
  output logic [15:0] o_rdata,
  output logic [15:0] o_ram_addr,
  output logic [15:0] o_ram_wdata,
  output logic        o_ram_rd,
  output logic        o_ram_wr,
  output logic        o_busy
);

  // Out-of-range parameter values saturate into the legal 1..WAIT_MAX window.
  localparam int unsigned WAIT_EFF = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX :
                                     ((WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  ram_req_t            r_acc, w_acc_nxt;
  logic                r_port, w_port_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;

  logic                r_cpu_gnt, w_cpu_gnt_nxt;
  logic                r_ldr_gnt, w_ldr_gnt_nxt;
  logic                r_cpu_ack, w_cpu_ack_nxt;
  logic                r_ldr_ack, w_ldr_ack_nxt;
  logic                r_ram_rd, w_ram_rd_nxt;
  logic                r_ram_wr, w_ram_wr_nxt;
  logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_nxt;
  logic [DATA_W-1:0]   r_ram_wdata, w_ram_wdata_nxt;
  logic                r_busy, w_busy_nxt;

  ram_req_t            w_cpu_acc;
  ram_req_t            w_ldr_acc;
  logic [1:0]          w_win;
  logic                w_last;

  assign w_cpu_acc = '{we: i_cpu_we, addr: i_cpu_addr, wdata: i_cpu_wdata};
  assign w_ldr_acc = '{we: i_ldr_we, addr: i_ldr_addr, wdata: i_ldr_wdata};

`ifdef RAM_ARB_RR_EN
  logic r_last, w_last_nxt;
  assign w_last = r_last;
`else
  assign w_last = PORT_LDR;
`endif

  ram_arb_pick u_pick (
    .i_cpu_req (i_cpu_req),
    .i_ldr_req (i_ldr_req),
    .i_last    (w_last),
    .o_win_c   (w_win)
  );

  // State, latched access and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_port      <= PORT_CPU;
      r_rdata     <= '0;
      r_cpu_gnt   <= 1'b0;
      r_ldr_gnt   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_ram_rd    <= 1'b0;
      r_ram_wr    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_busy      <= 1'b0;
`ifdef RAM_ARB_RR_EN
      r_last      <= PORT_LDR;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_port      <= w_port_nxt;
      r_rdata     <= w_rdata_nxt;
      r_cpu_gnt   <= w_cpu_gnt_nxt;
      r_ldr_gnt   <= w_ldr_gnt_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_ldr_ack   <= w_ldr_ack_nxt;
      r_ram_rd    <= w_ram_rd_nxt;
      r_ram_wr    <= w_ram_wr_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_busy      <= w_busy_nxt;
`ifdef RAM_ARB_RR_EN
      r_last      <= w_last_nxt;
`endif
    end
  end

  // Next-state logic; outputs are computed for the state being entered.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_acc_nxt     = r_acc;
    w_port_nxt    = r_port;
    w_rdata_nxt   = r_rdata;
    w_cpu_gnt_nxt = 1'b0;
    w_ldr_gnt_nxt = 1'b0;
    w_cpu_ack_nxt = 1'b0;
    w_ldr_ack_nxt = 1'b0;
`ifdef RAM_ARB_RR_EN
    w_last_nxt    = r_last;
`endif

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = CNT_LOAD;
        if (w_win != 2'b00) begin
          w_state_nxt   = ST_ACCESS;
          w_port_nxt    = w_win[PORT_LDR];
          w_acc_nxt     = w_win[PORT_LDR] ? w_ldr_acc : w_cpu_acc;
          w_cpu_gnt_nxt = w_win[PORT_CPU];
          w_ldr_gnt_nxt = w_win[PORT_LDR];
`ifdef RAM_ARB_RR_EN
          w_last_nxt    = w_win[PORT_LDR];
`endif
        end
      end
      ST_ACCESS: begin
        if (r_cnt <= CNT_ONE) begin
          w_state_nxt = ST_DONE;
          if (!r_acc.we) begin
            w_rdata_nxt = i_ram_rdata;
          end
          w_cpu_ack_nxt = (r_port == PORT_CPU);
          w_ldr_ack_nxt = (r_port == PORT_LDR);
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_ram_rd_nxt    = (w_state_nxt == ST_ACCESS) && !w_acc_nxt.we;
    w_ram_wr_nxt    = (w_state_nxt == ST_ACCESS) &&  w_acc_nxt.we;
    w_ram_addr_nxt  = (w_state_nxt == ST_ACCESS) ? w_acc_nxt.addr  : '0;
    w_ram_wdata_nxt = (w_state_nxt == ST_ACCESS) ? w_acc_nxt.wdata : '0;
  end

  assign o_cpu_gnt   = r_cpu_gnt;
  assign o_ldr_gnt   = r_ldr_gnt;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_ldr_ack   = r_ldr_ack;
  assign o_rdata     = r_rdata;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_rd    = r_ram_rd;
  assign o_ram_wr    = r_ram_wr;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench: two arbiters (WAIT_CYCLES 1 and 3) on shared stimulus, checked every
// cycle against a transaction-phase model, plus directed literal checks.
module tb_ram_port_arbiter;

  localparam int WV0 = 1;
  localparam int WV1 = 3;
`ifdef RAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, ldr_addr = '0, ldr_wdata = '0;

  logic        cpu_gnt [2];
  logic        ldr_gnt [2];
  logic        cpu_ack [2];
  logic        ldr_ack [2];
  logic        ram_rd  [2];
  logic        ram_wr  [2];
  logic        busy    [2];
  logic [15:0] rdata     [2];
  logic [15:0] ram_addr  [2];
  logic [15:0] ram_wdata [2];
  logic [15:0] ram_rdata [2];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural read-only RAM contents.
  function automatic logic [15:0] rom(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return (a * 16'd40503) ^ 16'h3C5A;
  endfunction

  assign ram_rdata[0] = rom(ram_addr[0]);
  assign ram_rdata[1] = rom(ram_addr[1]);

  ram_port_arbiter #(.WAIT_CYCLES(WV0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
    .i_ram_rdata(ram_rdata[0]),
    .o_cpu_gnt(cpu_gnt[0]), .o_ldr_gnt(ldr_gnt[0]), .o_cpu_ack(cpu_ack[0]), .o_ldr_ack(ldr_ack[0]),
    .o_rdata(rdata[0]), .o_ram_addr(ram_addr[0]), .o_ram_wdata(ram_wdata[0]),
    .o_ram_rd(ram_rd[0]), .o_ram_wr(ram_wr[0]), .o_busy(busy[0])
  );

  ram_port_arbiter #(.WAIT_CYCLES(WV1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .i_ldr_req(ldr_req), .i_ldr_we(ldr_we), .i_ldr_addr(ldr_addr), .i_ldr_wdata(ldr_wdata),
    .i_ram_rdata(ram_rdata[1]),
    .o_cpu_gnt(cpu_gnt[1]), .o_ldr_gnt(ldr_gnt[1]), .o_cpu_ack(cpu_ack[1]), .o_ldr_ack(ldr_ack[1]),
    .o_rdata(rdata[1]), .o_ram_addr(ram_addr[1]), .o_ram_wdata(ram_wdata[1]),
    .o_ram_rd(ram_rd[1]), .o_ram_wr(ram_wr[1]), .o_busy(busy[1])
  );

  // Model: phase 0 = idle, 1..W = access cycle number, W+1 = completion cycle.
  int          m_ph    [2];
  logic        m_port  [2];
  logic        m_we    [2];
  logic        m_last  [2];
  logic [15:0] m_addr  [2];
  logic [15:0] m_wdata [2];
  logic [15:0] m_rdata [2];

  function automatic int wcyc(input logic ix);
    return ix ? WV1 : WV0;
  endfunction

  task automatic chk1(input string name, input logic ix, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %b want %b at %0t", name, ix, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic ix, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", name, ix, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k]    = 0;
      m_port[k]  = 1'b0;
      m_we[k]    = 1'b0;
      m_last[k]  = 1'b1;
      m_addr[k]  = '0;
      m_wdata[k] = '0;
      m_rdata[k] = '0;
    end
  endtask

  task automatic model_one(input logic ix);
    logic p;
    int   w;
    w = wcyc(ix);
    if (m_ph[ix] == 0) begin
      if (cpu_req || ldr_req) begin
        if (cpu_req && ldr_req) p = RR_EN ? ~m_last[ix] : 1'b0;
        else                    p = ~cpu_req;
        m_port[ix]  = p;
        m_last[ix]  = p;
        m_we[ix]    = p ? ldr_we    : cpu_we;
        m_addr[ix]  = p ? ldr_addr  : cpu_addr;
        m_wdata[ix] = p ? ldr_wdata : cpu_wdata;
        m_ph[ix]    = 1;
      end
    end else if (m_ph[ix] < w) begin
      m_ph[ix] = m_ph[ix] + 1;
    end else if (m_ph[ix] == w) begin
      if (!m_we[ix]) m_rdata[ix] = rom(m_addr[ix]);
      m_ph[ix] = w + 1;
    end else begin
      m_ph[ix] = 0;
    end
  endtask

  task automatic compare_one(input logic ix);
    logic acc, done, first;
    acc   = (m_ph[ix] >= 1) && (m_ph[ix] <= wcyc(ix));
    done  = (m_ph[ix] == wcyc(ix) + 1);
    first = (m_ph[ix] == 1);
    chk1 ("busy",      ix, busy[ix],    m_ph[ix] != 0);
    chk1 ("cpu_gnt",   ix, cpu_gnt[ix], first && !m_port[ix]);
    chk1 ("ldr_gnt",   ix, ldr_gnt[ix], first &&  m_port[ix]);
    chk1 ("cpu_ack",   ix, cpu_ack[ix], done  && !m_port[ix]);
    chk1 ("ldr_ack",   ix, ldr_ack[ix], done  &&  m_port[ix]);
    chk1 ("ram_rd",    ix, ram_rd[ix],  acc && !m_we[ix]);
    chk1 ("ram_wr",    ix, ram_wr[ix],  acc &&  m_we[ix]);
    chk16("ram_addr",  ix, ram_addr[ix],  acc ? m_addr[ix]  : 16'h0000);
    chk16("ram_wdata", ix, ram_wdata[ix], acc ? m_wdata[ix] : 16'h0000);
    chk16("rdata",     ix, rdata[ix],     m_rdata[ix]);
  endtask

  // Inputs are already set (after a falling edge); advance one clock and check.
  task automatic step();
    model_one(1'b0);
    model_one(1'b1);
    @(posedge clk);
    @(negedge clk);
    compare_one(1'b0);
    compare_one(1'b1);
  endtask

  task automatic idle_steps(input int n);
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk1 ("rst_busy",  1'(k), busy[k],    1'b0);
      chk1 ("rst_rd",    1'(k), ram_rd[k],  1'b0);
      chk1 ("rst_wr",    1'(k), ram_wr[k],  1'b0);
      chk1 ("rst_cack",  1'(k), cpu_ack[k], 1'b0);
      chk1 ("rst_lack",  1'(k), ldr_ack[k], 1'b0);
      chk16("rst_rdata", 1'(k), rdata[k],   16'h0000);
    end
    @(posedge clk);
    @(negedge clk);
    compare_one(1'b0);
    compare_one(1'b1);
    rst_n = 1'b1;
  endtask

  int ngnt;
  logic exp_cpu;

  initial begin
    model_reset();
    @(negedge clk);
    compare_one(1'b0);
    compare_one(1'b1);
    chk16("reset_rdata", 1'b0, rdata[0], 16'h0000);
    rst_n = 1'b1;

    // cpu read of 0x0010, one wait cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    step();
    chk1 ("t33_gnt",  1'b0, cpu_gnt[0], 1'b1);
    chk1 ("t33_rd",   1'b0, ram_rd[0],  1'b1);
    chk16("t33_addr", 1'b0, ram_addr[0], 16'h0010);
    step();
    chk1 ("t33_ack",   1'b0, cpu_ack[0], 1'b1);
    chk1 ("t33_rd_lo", 1'b0, ram_rd[0],  1'b0);
    chk16("t33_rdata", 1'b0, rdata[0],   16'hBEEF);
    idle_steps(6);

    // loader write, three wait cycles
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0200; ldr_wdata = 16'h1234;
    step();
    chk1("t34_gnt", 1'b1, ldr_gnt[1], 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      chk1 ("t34_wr",    1'b1, ram_wr[1],    1'b1);
      chk16("t34_addr",  1'b1, ram_addr[1],  16'h0200);
      chk16("t34_wdata", 1'b1, ram_wdata[1], 16'h1234);
    end
    step();
    chk1 ("t34_ack",   1'b1, ldr_ack[1], 1'b1);
    chk1 ("t34_wr_lo", 1'b1, ram_wr[1],  1'b0);
    chk16("t34_rdata", 1'b1, rdata[1],   16'hBEEF);
    idle_steps(6);

    cpu_we = 1'b0; ldr_we = 1'b0; cpu_addr = 16'h0020; ldr_addr = 16'h0030;
`ifdef RAM_ARB_RR_EN
    // both held: grants alternate, cpu first since loader won last
    cpu_req = 1'b1; ldr_req = 1'b1;
    ngnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (cpu_gnt[0] || ldr_gnt[0]) begin
        exp_cpu = (ngnt % 2 == 0);
        chk1("rr_cpu_gnt", 1'b0, cpu_gnt[0], exp_cpu);
        chk1("rr_ldr_gnt", 1'b0, ldr_gnt[0], !exp_cpu);
        ngnt++;
      end
    end
    n_vec++;
    if (ngnt != 4) begin
      n_err++;
      $display("FAIL rr_grant_count: got %0d want 4", ngnt);
    end
`else
    // simultaneous requests: cpu first, loader three cycles later
    cpu_req = 1'b1; ldr_req = 1'b1;
    step();
    chk1("t35_cgnt", 1'b0, cpu_gnt[0], 1'b1);
    chk1("t35_lgnt", 1'b0, ldr_gnt[0], 1'b0);
    step();
    chk1("t35_cack", 1'b0, cpu_ack[0], 1'b1);
    cpu_req = 1'b0;
    step();
    chk1("t35_idle", 1'b0, busy[0], 1'b0);
    step();
    chk1("t35_lgnt2", 1'b0, ldr_gnt[0], 1'b1);
    step();
    chk1("t35_lack", 1'b0, ldr_ack[0], 1'b1);
`endif
    idle_steps(6);

    // cpu_req withdrawn mid-access still completes
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0044;
    step();
    chk1("t38_gnt", 1'b1, cpu_gnt[1], 1'b1);
    cpu_req = 1'b0;
    step();
    step();
    step();
    chk1 ("t38_ack",   1'b1, cpu_ack[1], 1'b1);
    chk16("t38_rdata", 1'b1, rdata[1],   rom(16'h0044));
    step();
    chk1("t38_ack_once", 1'b1, cpu_ack[1], 1'b0);
    idle_steps(6);

    // reset in the second of three access cycles, held request re-granted
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 16'hA5A5;
    step();
    step();
    chk1("t37_wr_pre", 1'b1, ram_wr[1], 1'b1);
    reset_pulse();
    step();
    chk1("t37_regnt", 1'b1, cpu_gnt[1], 1'b1);
    idle_steps(6);

    // randomized traffic, occasional asynchronous reset
    for (int n = 0; n < 4000; n++) begin
      cpu_req   = ($urandom_range(0, 2) != 0);
      ldr_req   = ($urandom_range(0, 2) != 0);
      cpu_we    = 1'($urandom_range(0, 1));
      ldr_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom);
      ldr_addr  = 16'($urandom);
      cpu_wdata = 16'($urandom);
      ldr_wdata = 16'($urandom);
      if ($urandom_range(0, 249) == 0) reset_pulse();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES SHALL default to 1; it is the number of cycles ram_rd/ram_wr are held per access, legal range 1..15.
REQ-002 clock  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 cpu_req  input  1  control-unit access request; held high until cpu_ack.
REQ-005 cpu_we  input  1  control-unit access is a write (1) or a read (0).
REQ-006 cpu_addr / cpu_wdata  input  16 each  control-unit address and write data.
REQ-007 ldr_req / ldr_we  input  1 each  loader-port request and write flag; same protocol as the cpu pair.
REQ-008 ldr_addr / ldr_wdata  input  16 each  loader-port address and write data.
REQ-009 cpu_gnt / ldr_gnt  output  1 each  one-cycle pulse: this requester won and its access has started.
REQ-010 cpu_ack / ldr_ack  output  1 each  one-cycle pulse: access complete; rdata valid for reads.
REQ-011 rdata  output  16  read data of the most recent completed read; held until the next read completes.
REQ-012 ram_addr / ram_wdata  output  16 each  RAM address and write data.
REQ-013 ram_rd / ram_wr  output  1 each  RAM read and write enables; mutually exclusive.
REQ-014 ram_rdata  input  16  RAM read data, valid during the last ACCESS cycle.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-017 IDLE -> ACCESS when any req is sampled high. The winner's we/addr/wdata are latched, and the winner's gnt is high for the first ACCESS cycle only.
REQ-018 ACCESS SHALL last exactly WAIT_CYCLES cycles, driving the latched ram_addr/ram_wdata and ram_rd (read) or ram_wr (write); a 4-bit counter loaded in IDLE tracks the cycles.
REQ-019 On the last ACCESS cycle, a read SHALL capture ram_rdata into rdata at the clock edge; the state then goes to DONE.
REQ-020 DONE SHALL last exactly one cycle, with the winner's ack high and ram_rd/ram_wr low; the state then returns to IDLE unconditionally.
REQ-021 Latency from the req-sampling edge to ack high SHALL be WAIT_CYCLES+1 cycles; minimum spacing between successive accesses is WAIT_CYCLES+2 cycles.
REQ-022 A requester SHALL drop req in the cycle after ack; a req still high in IDLE is treated as a new request.
REQ-023 If req is withdrawn during ACCESS, the access SHALL still complete and ack SHALL still pulse.
REQ-024 Address, data and we changes during ACCESS/DONE SHALL be ignored (latched values only).
REQ-025 Simultaneous requests, default arbitration: the cpu port SHALL win (fixed priority).
REQ-026 gnt and ack SHALL never be high for both ports in the same cycle.

Reset
REQ-027 reset low SHALL immediately force IDLE, counter=0, last-winner=ldr, rdata=0, and all outputs low.
REQ-028 Reset mid-ACCESS SHALL abort the access with no ack; after release, pending reqs are re-arbitrated from IDLE.

Configuration
REQ-029 Macro RAM_ARB_RR_EN defined: simultaneous requests SHALL be resolved round-robin. The port not granted last wins, and last-winner updates on each grant.
REQ-030 RAM_ARB_RR_EN undefined: fixed cpu priority per REQ-025, and the last-winner register is not built.

Structure
REQ-031 State encodings (IDLE=0, ACCESS=1, DONE=2), port-index constants (CPU=0, LDR=1) and the WAIT_CYCLES legal maximum SHALL live in the shared package cpu16_pkg.
REQ-032 Winner selection SHALL be a sub-module ram_arb_pick (combinational, req pair + last-winner in, one-hot winner out); everything else stays in ram_port_arbiter.

Verification
REQ-033 WAIT_CYCLES=1, cpu read at addr 0x0010, RAM returns 0xBEEF -> ram_rd for 1 cycle, cpu_ack 2 cycles after req sampled, rdata=0xBEEF.
REQ-034 WAIT_CYCLES=3, ldr write 0x1234 to addr 0x0200 -> ram_wr high 3 cycles with ram_addr=0x0200 and ram_wdata=0x1234, ldr_ack on cycle 4, rdata unchanged.
REQ-035 Both reqs high together, macro undefined -> cpu_gnt first, then ldr_gnt 3 cycles later (WAIT_CYCLES=1).
REQ-036 Both reqs held continuously, RAM_ARB_RR_EN defined -> grants alternate cpu, ldr, cpu, ldr.
REQ-037 reset driven low in the 2nd of 3 ACCESS cycles -> all outputs 0 immediately, no ack, busy=0; after release a held cpu_req is re-granted.
REQ-038 cpu_req dropped mid-ACCESS -> access completes and cpu_ack still pulses once.
